// File: rtl/m2v_block_sched_if.sv
// Handshake bundle between the block scheduler and its VLD / IDCT neighbours.
// master: scheduler side, slave: pipeline side.
interface m2v_block_sched_if;
    logic blk_req;
    logic ds_ready;
    logic flush;
    logic pre_block_start;
    logic block_start;
    logic blk_ack;
    logic bubble;
    logic busy;
    logic flush_done;

    modport master (
        input  blk_req,
        input  ds_ready,
        input  flush,
        output pre_block_start,
        output block_start,
        output blk_ack,
        output bubble,
        output busy,
        output flush_done
    );

    modport slave (
        output blk_req,
        output ds_ready,
        output flush,
        input  pre_block_start,
        input  block_start,
        input  blk_ack,
        input  bubble,
        input  busy,
        input  flush_done
    );
endinterface

// File: rtl/m2v_block_sched.sv
// Block scheduler for the m2vside1..3 side-info pipeline and IDCT.
// Issues pre_block_start/block_start pairs, spaced and drained on flush.
module m2v_block_sched #(
    parameter int unsigned BLK_INTERVAL = 64,
    parameter int unsigned CNT_WIDTH    = 7,
    parameter int unsigned DRAIN_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    m2v_block_sched_if.master bus
);

    localparam int unsigned DW = $clog2(DRAIN_DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(BLK_INTERVAL - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_DEPTH);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        START = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [DW-1:0]        drain_cnt;
    logic                 kind_real;
    logic                 kind_real_nx;
    logic                 done_pend;

    logic                 at_decision;
    logic                 drain_want;
    logic                 go_real;
    logic                 go_drain;
    logic                 start_real;
    logic                 start_bubble;
    logic                 done_fire;

    // Decision terms; a flush in the decision cycle already counts as a drain request.
    always_comb begin
        at_decision = 1'b0;
        drain_want  = 1'b0;
        go_real     = 1'b0;
        go_drain    = 1'b0;
        at_decision = (state == IDLE) && (cnt <= CNT_WIDTH'(1));
        drain_want  = (drain_cnt != '0) || bus.flush;
        go_real     = bus.blk_req & bus.ds_ready;
        go_drain    = ~bus.blk_req & bus.ds_ready & drain_want;
    end

    // Next state and block kind; PRE is committed and always proceeds to START.
    always_comb begin
        state_nx     = state;
        kind_real_nx = kind_real;
        unique case (state)
            IDLE: begin
                if (at_decision && (go_real || go_drain)) begin
                    state_nx     = PRE;
                    kind_real_nx = go_real;
                end
            end
            PRE:     state_nx = START;
            START:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State and latched block kind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            kind_real <= 1'b0;
        end else begin
            state     <= state_nx;
            kind_real <= kind_real_nx;
        end
    end

    // Interval counter holds BLK_INTERVAL-1 during the block_start cycle, then counts down.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == PRE) begin
            cnt <= CNT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end

    assign start_real   = (state == START) && kind_real;
    assign start_bubble = (state == START) && !kind_real;

    // Outstanding bubbles: flush or a real block mid-drain rearm, each bubble consumes one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_cnt <= '0;
        end else if (bus.flush) begin
            drain_cnt <= DRAIN_LOAD;
        end else if (start_real && (drain_cnt != '0)) begin
            drain_cnt <= DRAIN_LOAD;
        end else if (start_bubble && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - DW'(1);
        end
    end

    assign done_fire = done_pend && (state == IDLE) && (cnt == '0);

    // Final bubble arms flush_done; a real block or new flush cancels it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_pend <= 1'b0;
        end else if (bus.flush || start_real) begin
            done_pend <= 1'b0;
        end else if (start_bubble && (drain_cnt == DRAIN_ONE)) begin
            done_pend <= 1'b1;
        end else if (done_fire) begin
            done_pend <= 1'b0;
        end
    end

    assign bus.pre_block_start = (state == PRE);
    assign bus.block_start     = (state == START);
    assign bus.blk_ack         = start_real;
    assign bus.bubble          = start_bubble;
    assign bus.flush_done      = done_fire;
    assign bus.busy            = !((state == IDLE) && (cnt == '0) &&
                                   (drain_cnt == '0) && !done_pend);

endmodule

// File: tb/tb_m2v_block_sched.sv
// Directed bench for m2v_block_sched with an event scoreboard.
// Expected pulse events are queued per step and matched against observed ones.
module tb_m2v_block_sched;

    localparam int EV_P = 0;
    localparam int EV_A = 1;
    localparam int EV_B = 2;
    localparam int EV_D = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   exp_q[$];
    int   obs_q[$];

    m2v_block_sched_if bus();

    m2v_block_sched #(
        .BLK_INTERVAL (64),
        .CNT_WIDTH    (7),
        .DRAIN_DEPTH  (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Cycle index: first decision cycle after reset release is cycle 0.
    always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

    // Record observed pulses and check the output invariants every cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.pre_block_start) obs_q.push_back(cyc * 4 + EV_P);
            if (bus.blk_ack)         obs_q.push_back(cyc * 4 + EV_A);
            if (bus.bubble)          obs_q.push_back(cyc * 4 + EV_B);
            if (bus.flush_done)      obs_q.push_back(cyc * 4 + EV_D);
            n_assert++;
            assert ((bus.blk_ack | bus.bubble) === bus.block_start) else begin
                n_fail++;
                $error("FAIL kind_vs_start cyc%0d observed %b expected %b",
                       cyc, bus.blk_ack | bus.bubble, bus.block_start);
            end
            n_assert++;
            assert ((bus.blk_ack & bus.bubble) === 1'b0) else begin
                n_fail++;
                $error("FAIL ack_bubble_excl cyc%0d observed 1 expected 0", cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic expect_ev(input int c, input int code);
        exp_q.push_back(c * 4 + code);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_events(input string tag);
        int e;
        int o;
        n_assert++;
        assert (obs_q.size() === exp_q.size()) else begin
            n_fail++;
            $error("FAIL %s_count observed %0d expected %0d",
                   tag, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_assert++;
            assert (o === e) else begin
                n_fail++;
                $error("FAIL %s_event observed cyc%0d/k%0d expected cyc%0d/k%0d",
                       tag, o / 4, o % 4, e / 4, e % 4);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset(input logic req, input logic rdy);
        logic [5:0] outs;
        @(negedge clk);
        reset_n      = 1'b0;
        bus.blk_req  = req;
        bus.ds_ready = rdy;
        bus.flush    = 1'b0;
        repeat (2) @(negedge clk);
        outs = {bus.pre_block_start, bus.block_start, bus.blk_ack,
                bus.bubble, bus.busy, bus.flush_done};
        n_assert++;
        assert (outs === 6'b0) else begin
            n_fail++;
            $error("FAIL reset_outputs observed %b expected 000000", outs);
        end
        obs_q.delete();
        exp_q.delete();
        reset_n = 1'b1;
    endtask

    initial begin
        bus.blk_req  = 1'b0;
        bus.ds_ready = 1'b0;
        bus.flush    = 1'b0;

        // Back-to-back real blocks at the interval rate.
        do_reset(1'b1, 1'b1);
        expect_ev(1, EV_P);   expect_ev(2, EV_A);
        expect_ev(65, EV_P);  expect_ev(66, EV_A);
        expect_ev(129, EV_P); expect_ev(130, EV_A);
        wait_cyc(135);
        check_events("t1_rate");

        // Downstream stall holds the scheduler in IDLE.
        do_reset(1'b1, 1'b1);
        wait_cyc(60);
        bus.ds_ready = 1'b0;
        wait_cyc(100);
        bus.ds_ready = 1'b1;
        expect_ev(1, EV_P);   expect_ev(2, EV_A);
        expect_ev(101, EV_P); expect_ev(102, EV_A);
        expect_ev(165, EV_P); expect_ev(166, EV_A);
        wait_cyc(170);
        check_events("t2_stall");

        // blk_req dropped while in PRE: block still issued.
        do_reset(1'b1, 1'b1);
        wait_cyc(1);
        check_bit("t3_pre", bus.pre_block_start, 1'b1);
        bus.blk_req = 1'b0;
        expect_ev(1, EV_P); expect_ev(2, EV_A);
        wait_cyc(140);
        check_events("t3_commit");

        // Flush on an idle pipe: two bubbles then flush_done.
        do_reset(1'b0, 1'b1);
        wait_cyc(5);
        check_bit("t4_idle_busy", bus.busy, 1'b0);
        wait_cyc(10);
        bus.flush = 1'b1;
        wait_cyc(11);
        bus.flush = 1'b0;
        check_bit("t4_draining_busy", bus.busy, 1'b1);
        expect_ev(11, EV_P); expect_ev(12, EV_B);
        expect_ev(75, EV_P); expect_ev(76, EV_B);
        expect_ev(139, EV_D);
        wait_cyc(138);
        check_bit("t4_busy_138", bus.busy, 1'b1);
        wait_cyc(140);
        check_bit("t4_busy_140", bus.busy, 1'b0);
        wait_cyc(145);
        check_events("t4_flush");

        // Real block mid-drain rearms the drain count.
        do_reset(1'b0, 1'b1);
        wait_cyc(10);
        bus.flush = 1'b1;
        wait_cyc(11);
        bus.flush = 1'b0;
        wait_cyc(20);
        bus.blk_req = 1'b1;
        wait_cyc(75);
        bus.blk_req = 1'b0;
        expect_ev(11, EV_P);  expect_ev(12, EV_B);
        expect_ev(75, EV_P);  expect_ev(76, EV_A);
        expect_ev(139, EV_P); expect_ev(140, EV_B);
        expect_ev(203, EV_P); expect_ev(204, EV_B);
        expect_ev(267, EV_D);
        wait_cyc(275);
        check_bit("t5_busy_end", bus.busy, 1'b0);
        check_events("t5_rearm");

        // Async reset in the START cycle, then restart from zero.
        do_reset(1'b1, 1'b1);
        wait_cyc(1);
        @(posedge clk);
        #1;
        check_bit("t6_in_start", bus.block_start, 1'b1);
        reset_n = 1'b0;
        #1;
        check_bit("t6_rst_start", bus.block_start, 1'b0);
        check_bit("t6_rst_ack", bus.blk_ack, 1'b0);
        check_bit("t6_rst_busy", bus.busy, 1'b0);
        expect_ev(1, EV_P);
        check_events("t6_before");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        expect_ev(1, EV_P);  expect_ev(2, EV_A);
        expect_ev(65, EV_P); expect_ev(66, EV_A);
        wait_cyc(70);
        bus.blk_req = 1'b0;
        wait_cyc(135);
        check_bit("t6_busy_end", bus.busy, 1'b0);
        check_events("t6_restart");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
